// File: rtl/video_scanout_if.sv
// Renderer-to-scanout pixel write stream: one pixel write per color_ready strobe,
// plus the frame-complete flag that requests a buffer swap.
interface video_scanout_if;
    logic [7:0] hh;
    logic [7:0] vv;
    logic [2:0] red;
    logic [2:0] green;
    logic [1:0] blue;
    logic       color_ready;
    logic       frame;

    modport master (output hh, vv, red, green, blue, color_ready, frame);
    modport slave  (input  hh, vv, red, green, blue, color_ready, frame);
endinterface

// File: rtl/video_scanout.sv
// video_scanout: double-buffered 256x256 RGB332 frame buffer scanned out with fixed CRT timing.
// Build macro SCANOUT_SCANLINE_EN: halve every colour component on odd visible lines.
module video_scanout #(
    parameter int CE_DIV   = 8,
    parameter int H_TOTAL  = 384,
    parameter int H_ACTIVE = 256,
    parameter int HS_START = 304,
    parameter int HS_WIDTH = 32,
    parameter int V_TOTAL  = 264,
    parameter int V_ACTIVE = 224,
    parameter int V_OFFSET = 16,
    parameter int VS_START = 240,
    parameter int VS_WIDTH = 4
) (
    input  logic                  clk_sys,
    input  logic                  reset_n,
    video_scanout_if.slave        pix,
    output logic                  ce_pix,
    output logic [2:0]            r_out,
    output logic [2:0]            g_out,
    output logic [1:0]            b_out,
    output logic                  hsync,
    output logic                  vsync,
    output logic                  hblank,
    output logic                  vblank,
    output logic                  vs_n,
    output logic                  front_bank
);
    localparam int              CE_W      = (CE_DIV > 2) ? $clog2(CE_DIV) : 1;
    localparam logic [CE_W-1:0] CE_LAST_C = CE_W'(CE_DIV - 1);
    localparam logic [CE_W-1:0] CE_ONE_C  = CE_W'(1);
    localparam logic [8:0]      H_LAST_C  = 9'(H_TOTAL - 1);
    localparam logic [8:0]      H_ACT_C   = 9'(H_ACTIVE);
    localparam logic [8:0]      HS_BEG_C  = 9'(HS_START);
    localparam logic [8:0]      HS_END_C  = 9'(HS_START + HS_WIDTH);
    localparam logic [8:0]      V_LAST_C  = 9'(V_TOTAL - 1);
    localparam logic [8:0]      V_ACT_C   = 9'(V_ACTIVE);
    localparam logic [8:0]      V_SWAP_C  = 9'(V_ACTIVE - 1);
    localparam logic [8:0]      VS_BEG_C  = 9'(VS_START);
    localparam logic [8:0]      VS_END_C  = 9'(VS_START + VS_WIDTH);
    localparam logic [7:0]      V_OFF_C   = 8'(V_OFFSET);

    typedef enum logic [0:0] {
        SWAP_IDLE    = 1'b0,
        SWAP_PENDING = 1'b1
    } swap_state_t;

    logic [CE_W-1:0] ce_cnt_r;
    logic            ce_pix_r;
    logic [8:0]      hcnt_r;
    logic [8:0]      vcnt_r;
    logic [8:0]      hcnt_s;
    logic [8:0]      vcnt_s;
    swap_state_t     swap_state_r;
    swap_state_t     swap_state_s;
    logic            front_bank_r;
    logic            front_bank_s;
    logic            swap_point_s;
    logic [7:0]      fb_mem_r [0:131071];
    logic [7:0]      rd_data_r;
    logic [16:0]     wr_addr_s;
    logic [16:0]     rd_addr_s;
    logic [7:0]      rgb_s;
    logic            hblank_s;
    logic            vblank_s;
    logic            hsync_s;
    logic            vsync_s;
    logic [2:0]      r_out_r;
    logic [2:0]      g_out_r;
    logic [1:0]      b_out_r;
    logic            hsync_r;
    logic            vsync_r;
    logic            hblank_r;
    logic            vblank_r;
    logic            vs_n_r;

    // Pixel clock enable: one-cycle pulse every CE_DIV clk_sys cycles
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            ce_cnt_r <= {CE_W{1'b0}};
            ce_pix_r <= 1'b0;
        end else if (ce_cnt_r == CE_LAST_C) begin
            ce_cnt_r <= {CE_W{1'b0}};
            ce_pix_r <= 1'b1;
        end else begin
            ce_cnt_r <= ce_cnt_r + CE_ONE_C;
            ce_pix_r <= 1'b0;
        end
    end

    // Next beam position
    always_comb begin
        hcnt_s = hcnt_r;
        vcnt_s = vcnt_r;
        if (ce_pix_r) begin
            if (hcnt_r == H_LAST_C) begin
                hcnt_s = 9'd0;
                if (vcnt_r == V_LAST_C) begin
                    vcnt_s = 9'd0;
                end else begin
                    vcnt_s = vcnt_r + 9'd1;
                end
            end else begin
                hcnt_s = hcnt_r + 9'd1;
                vcnt_s = vcnt_r;
            end
        end else begin
            hcnt_s = hcnt_r;
            vcnt_s = vcnt_r;
        end
    end

    // Swap handshake: a frame strobe on the swap edge itself is honoured immediately
    always_comb begin
        swap_state_s = swap_state_r;
        front_bank_s = front_bank_r;
        if (ce_pix_r && (hcnt_r == H_LAST_C) && (vcnt_r == V_SWAP_C)) begin
            swap_point_s = 1'b1;
        end else begin
            swap_point_s = 1'b0;
        end
        case (swap_state_r)
            SWAP_IDLE: begin
                if (swap_point_s) begin
                    front_bank_s = pix.frame ? ~front_bank_r : front_bank_r;
                    swap_state_s = SWAP_IDLE;
                end else if (pix.frame) begin
                    swap_state_s = SWAP_PENDING;
                end else begin
                    swap_state_s = SWAP_IDLE;
                end
            end
            SWAP_PENDING: begin
                if (swap_point_s) begin
                    front_bank_s = ~front_bank_r;
                    swap_state_s = SWAP_IDLE;
                end else begin
                    swap_state_s = SWAP_PENDING;
                end
            end
            default: begin
                swap_state_s = SWAP_IDLE;
                front_bank_s = front_bank_r;
            end
        endcase
    end

    // Beam counters and bank selection state
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            hcnt_r       <= 9'd0;
            vcnt_r       <= 9'd0;
            swap_state_r <= SWAP_IDLE;
            front_bank_r <= 1'b0;
        end else begin
            hcnt_r       <= hcnt_s;
            vcnt_r       <= vcnt_s;
            swap_state_r <= swap_state_s;
            front_bank_r <= front_bank_s;
        end
    end

    // Writes always target the bank not being shown at the time of the strobe
    assign wr_addr_s = {~front_bank_r, pix.vv, pix.hh};
    assign rd_addr_s = {front_bank_r, vcnt_r[7:0] + V_OFF_C, hcnt_r[7:0]};

    // Frame buffer RAM: contents survive reset
    always_ff @(posedge clk_sys) begin
        if (pix.color_ready) begin
            fb_mem_r[wr_addr_s] <= {pix.red, pix.green, pix.blue};
        end
        rd_data_r <= fb_mem_r[rd_addr_s];
    end

    // Timing decode and colour selection for the current beam position
    always_comb begin
        hblank_s = (hcnt_r >= H_ACT_C);
        vblank_s = (vcnt_r >= V_ACT_C);
        hsync_s  = (hcnt_r >= HS_BEG_C) && (hcnt_r < HS_END_C);
        vsync_s  = (vcnt_r >= VS_BEG_C) && (vcnt_r < VS_END_C);
        rgb_s    = 8'd0;
        if (!hblank_s && !vblank_s) begin
`ifdef SCANOUT_SCANLINE_EN
            if (vcnt_r[0]) begin
                rgb_s = {1'b0, rd_data_r[7:6], 1'b0, rd_data_r[4:3], 1'b0, rd_data_r[1]};
            end else begin
                rgb_s = rd_data_r;
            end
`else
            rgb_s = rd_data_r;
`endif
        end else begin
            rgb_s = 8'd0;
        end
    end

    // Output pipeline: one pixel behind the counters, all fields aligned
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            r_out_r  <= 3'd0;
            g_out_r  <= 3'd0;
            b_out_r  <= 2'd0;
            hsync_r  <= 1'b0;
            vsync_r  <= 1'b0;
            hblank_r <= 1'b1;
            vblank_r <= 1'b1;
            vs_n_r   <= 1'b1;
        end else if (ce_pix_r) begin
            r_out_r  <= rgb_s[7:5];
            g_out_r  <= rgb_s[4:2];
            b_out_r  <= rgb_s[1:0];
            hsync_r  <= hsync_s;
            vsync_r  <= vsync_s;
            hblank_r <= hblank_s;
            vblank_r <= vblank_s;
            vs_n_r   <= ~vsync_s;
        end
    end

    assign ce_pix     = ce_pix_r;
    assign r_out      = r_out_r;
    assign g_out      = g_out_r;
    assign b_out      = b_out_r;
    assign hsync      = hsync_r;
    assign vsync      = vsync_r;
    assign hblank     = hblank_r;
    assign vblank     = vblank_r;
    assign vs_n       = vs_n_r;
    assign front_bank = front_bank_r;
endmodule

// File: tb/tb_video_scanout.sv
// Scoreboard bench for video_scanout on a shrunken raster so several frames fit a short run.
module tb_video_scanout;
    localparam int CE_DIV   = 3;
    localparam int H_TOTAL  = 80;
    localparam int H_ACTIVE = 64;
    localparam int HS_START = 68;
    localparam int HS_WIDTH = 6;
    localparam int V_TOTAL  = 16;
    localparam int V_ACTIVE = 10;
    localparam int V_OFFSET = 16;
    localparam int VS_START = 12;
    localparam int VS_WIDTH = 2;
    localparam int LIMIT    = 2 * V_TOTAL * H_TOTAL * CE_DIV;
`ifdef SCANOUT_SCANLINE_EN
    localparam logic [7:0] ODD_FF_EXP = 8'h6D;
`else
    localparam logic [7:0] ODD_FF_EXP = 8'hFF;
`endif

    logic       clk_sys = 1'b0;
    logic       reset_n = 1'b0;
    logic       ce_pix, hsync, vsync, hblank, vblank, vs_n, front_bank;
    logic [2:0] r_out, g_out;
    logic [1:0] b_out;

    video_scanout_if pix_if ();

    video_scanout #(
        .CE_DIV(CE_DIV), .H_TOTAL(H_TOTAL), .H_ACTIVE(H_ACTIVE), .HS_START(HS_START),
        .HS_WIDTH(HS_WIDTH), .V_TOTAL(V_TOTAL), .V_ACTIVE(V_ACTIVE), .V_OFFSET(V_OFFSET),
        .VS_START(VS_START), .VS_WIDTH(VS_WIDTH)
    ) dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .pix(pix_if.slave), .ce_pix(ce_pix),
        .r_out(r_out), .g_out(g_out), .b_out(b_out), .hsync(hsync), .vsync(vsync),
        .hblank(hblank), .vblank(vblank), .vs_n(vs_n), .front_bank(front_bank)
    );

    always #5 clk_sys = ~clk_sys;

    int checks   = 0;
    int failures = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [13:0] val;
        logic [13:0] mask;
        int          h;
        int          v;
        bit          rst;
    } exp_t;

    exp_t       exp_q[$];
    int         m_cnt, m_h, m_v;
    bit         m_ce, m_front, m_pend;
    bit         color_known = 1'b0;
    logic [7:0] m_mem [0:1][0:65535];
    logic [7:0] cap [0:1][0:7];
    int         pix_idx, hs_cnt, hb_cnt;

    // Reference model: expected output of each pixel, queued at the edge that produces it
    always @(posedge clk_sys) begin : ref_model
        exp_t       e;
        logic [7:0] px;
        bit         vis, swp, have;
        if (!reset_n) begin
            m_cnt = 0; m_ce = 1'b0; m_h = 0; m_v = 0; m_front = 1'b0; m_pend = 1'b0;
            e.val = 14'h000E; e.mask = 14'h3FFF; e.h = -1; e.v = -1; e.rst = 1'b1;
            exp_q.delete();
            exp_q.push_back(e);
        end else begin
            swp = 1'b0; have = 1'b0;
            if (m_ce) begin
                vis = (m_h < H_ACTIVE) && (m_v < V_ACTIVE);
                px  = vis ? m_mem[m_front][{8'(m_v + V_OFFSET), 8'(m_h)}] : 8'h00;
`ifdef SCANOUT_SCANLINE_EN
                if (vis && (m_v % 2 == 1)) px = {1'b0, px[7:6], 1'b0, px[4:3], 1'b0, px[1]};
`endif
                e.val = {px, 1'(m_h >= HS_START && m_h < HS_START + HS_WIDTH),
                         1'(m_v >= VS_START && m_v < VS_START + VS_WIDTH),
                         1'(m_h >= H_ACTIVE), 1'(m_v >= V_ACTIVE),
                         1'(!(m_v >= VS_START && m_v < VS_START + VS_WIDTH)), 1'b0};
                e.mask = color_known ? 14'h3FFF : 14'h003F;
                e.h = m_h; e.v = m_v; e.rst = 1'b0; have = 1'b1;
                swp = (m_h == H_TOTAL - 1) && (m_v == V_ACTIVE - 1);
                if (m_h == H_TOTAL - 1) begin
                    m_h = 0;
                    m_v = (m_v == V_TOTAL - 1) ? 0 : m_v + 1;
                end else begin
                    m_h = m_h + 1;
                end
            end
            if (pix_if.color_ready)
                m_mem[!m_front][{pix_if.vv, pix_if.hh}] = {pix_if.red, pix_if.green, pix_if.blue};
            if (swp) begin
                if (m_pend || pix_if.frame) m_front = !m_front;
                m_pend = 1'b0;
            end else if (pix_if.frame) begin
                m_pend = 1'b1;
            end
            if (have) begin
                e.val[0] = m_front;
                exp_q.push_back(e);
            end
            if (m_cnt == CE_DIV - 1) begin
                m_cnt = 0; m_ce = 1'b1;
            end else begin
                m_cnt = m_cnt + 1; m_ce = 1'b0;
            end
        end
    end

    // Scoreboard: pop one expected pixel per produced output, check ce_pix every cycle
    always @(negedge clk_sys) begin : sb_check
        exp_t        e;
        logic [13:0] got;
        check_val("ce_pix", 32'(ce_pix), 32'(m_ce));
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            got = {r_out, g_out, b_out, hsync, vsync, hblank, vblank, vs_n, front_bank};
            check_val($sformatf("pixel h%0d v%0d", e.h, e.v), 32'(got & e.mask), 32'(e.val & e.mask));
            if (e.rst) begin
                pix_idx = 0; hs_cnt = 0; hb_cnt = 0;
            end else begin
                if (pix_idx < 10 * H_TOTAL) begin
                    hs_cnt += int'(hsync);
                    hb_cnt += int'(hblank);
                end
                pix_idx++;
                if (e.v < 2 && e.h < 8) cap[e.v][e.h] = {r_out, g_out, b_out};
            end
        end
    end

    task automatic drive_px(input int h, input int v, input logic [7:0] rgb);
        pix_if.hh = 8'(h); pix_if.vv = 8'(v);
        pix_if.red = rgb[7:5]; pix_if.green = rgb[4:2]; pix_if.blue = rgb[1:0];
        pix_if.color_ready = 1'b1;
    endtask

    task automatic write_px(input int h, input int v, input logic [7:0] rgb);
        drive_px(h, v, rgb);
        @(negedge clk_sys);
        pix_if.color_ready = 1'b0;
    endtask

    task automatic fill_back();
        for (int r = V_OFFSET; r < V_OFFSET + V_ACTIVE; r++) begin
            for (int c = 0; c < H_ACTIVE; c++) begin
                drive_px(c, r, 8'h00);
                @(negedge clk_sys);
            end
        end
        pix_if.color_ready = 1'b0;
    endtask

    task automatic pulse_frame();
        pix_if.frame = 1'b1;
        @(negedge clk_sys);
        pix_if.frame = 1'b0;
    endtask

    task automatic wait_at(input int h, input int v);
        int n   = 0;
        bit hit = 1'b0;
        while (!hit && n < LIMIT) begin
            @(negedge clk_sys);
            n++;
            hit = m_ce && (m_h == h) && (m_v == v);
        end
        check_val($sformatf("reach h%0d v%0d", h, v), 32'(hit), 32'd1);
    endtask

    task automatic wait_swap();
        wait_at(H_TOTAL - 1, V_ACTIVE - 1);
        @(negedge clk_sys);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stimulus
        int n;
        pix_if.hh = 8'd0; pix_if.vv = 8'd0; pix_if.red = 3'd0; pix_if.green = 3'd0;
        pix_if.blue = 2'd0; pix_if.color_ready = 1'b0; pix_if.frame = 1'b0;
        repeat (3) @(negedge clk_sys);
        reset_n = 1'b1;

        n = 0;
        do begin @(negedge clk_sys); n++; end while (!ce_pix && n < 20);
        check_val("ce_first_pulse", 32'(n), 32'(CE_DIV));
        n = 0;
        do begin @(negedge clk_sys); n++; end while (!ce_pix && n < 20);
        check_val("ce_period", 32'(n), 32'(CE_DIV));

        n = 0;
        while (pix_idx < 10 * H_TOTAL && n < LIMIT) begin @(negedge clk_sys); n++; end
        check_val("ten_lines", 32'(pix_idx >= 10 * H_TOTAL), 32'd1);
        check_val("hsync_count", 32'(hs_cnt), 32'(10 * HS_WIDTH));
        check_val("hblank_count", 32'(hb_cnt), 32'(10 * (H_TOTAL - H_ACTIVE)));

        fill_back();
        pulse_frame();
        wait_swap();
        check_val("prefill_swap", 32'(front_bank), 32'd1);
        fill_back();
        color_known = 1'b1;

        write_px(3, V_OFFSET, {3'd7, 3'd4, 2'd1});
        pulse_frame();
        wait_swap();
        check_val("swap_to_bank0", 32'(front_bank), 32'd0);
        wait_at(0, 2);
        check_val("px3_r", 32'(cap[0][3][7:5]), 32'd7);
        check_val("px3_g", 32'(cap[0][3][4:2]), 32'd4);
        check_val("px3_b", 32'(cap[0][3][1:0]), 32'd1);
        check_val("px2_black", 32'(cap[0][2]), 32'd0);
        check_val("px4_black", 32'(cap[0][4]), 32'd0);

        wait_swap();
        check_val("no_frame_hold", 32'(front_bank), 32'd0);

        wait_at(0, 1);
        pulse_frame();
        wait_at(0, 4);
        pulse_frame();
        wait_swap();
        check_val("double_frame_toggle", 32'(front_bank), 32'd1);
        wait_swap();
        check_val("double_frame_once", 32'(front_bank), 32'd1);

        wait_at(H_TOTAL - 1, V_ACTIVE - 1);
        drive_px(7, V_OFFSET, 8'h9A);
        pix_if.frame = 1'b1;
        @(negedge clk_sys);
        pix_if.frame = 1'b0;
        pix_if.color_ready = 1'b0;
        check_val("swap_point_toggle", 32'(front_bank), 32'd0);
        wait_at(0, 2);
        check_val("swap_point_write", 32'(cap[0][7]), 32'h9A);
        wait_swap();
        check_val("swap_point_no_pending", 32'(front_bank), 32'd0);

        write_px(5, V_OFFSET, 8'hFF);
        write_px(5, V_OFFSET + 1, 8'hFF);
        pulse_frame();
        wait_swap();
        check_val("scan_swap", 32'(front_bank), 32'd1);
        wait_at(0, 2);
        check_val("scan_line0", 32'(cap[0][5]), 32'hFF);
        check_val("scan_line1", 32'(cap[1][5]), 32'(ODD_FF_EXP));

        pulse_frame();
        wait_at(50, 5);
        reset_n = 1'b0;
        @(negedge clk_sys);
        check_val("reset_outputs",
                  32'({r_out, g_out, b_out, hsync, vsync, hblank, vblank, vs_n, front_bank}),
                  32'h000E);
        check_val("reset_ce", 32'(ce_pix), 32'd0);
        reset_n = 1'b1;
        wait_swap();
        check_val("reset_clears_pending", 32'(front_bank), 32'd0);

        repeat (4) @(negedge clk_sys);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
